// File: rtl/npu_pkg.sv
// Shared definitions for the conv-datapath weight store.
//   kk_f     : taps per kernel for a given kernel edge
//   idx_w_f  : index width for N entries, never less than one bit
//   load_state_e : kernel load FSM states
package npu_pkg;

  function automatic int kk_f(input int ks);
    return ks * ks;
  endfunction

  function automatic int idx_w_f(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } load_state_e;

endpackage

// File: rtl/kernel_bank_buf_if.sv
// Host/MAC-side bus of the kernel bank buffer.
//   load_*     : kernel load command (start, slot, abort) and done pulse
//   s_*        : tap stream, valid/ready
//   swap_*     : bank swap request / ack, shadow_full status
//   rd_*       : whole-kernel read from the active bank, 1-cycle latency
//   active_bank: current active bank index
// master = host/MAC side, slave = kernel_bank_buf.
interface kernel_bank_buf_if
  import npu_pkg::*;
#(
  parameter int BIT_DEPTH   = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int NUM_KERNELS = 4
);
  localparam int KK    = kk_f(KERNEL_SIZE);
  localparam int KID_W = idx_w_f(NUM_KERNELS);

  logic                    load_start;
  logic [KID_W-1:0]        load_kid;
  logic                    load_abort;
  logic                    s_valid;
  logic                    s_ready;
  logic [BIT_DEPTH-1:0]    s_data;
  logic                    load_done;
  logic                    swap_req;
  logic                    swap_ack;
  logic                    shadow_full;
  logic                    rd_en;
  logic [KID_W-1:0]        rd_kid;
  logic                    rd_valid;
  logic [KK*BIT_DEPTH-1:0] rd_taps;
  logic                    active_bank;

  modport master (
    output load_start, load_kid, load_abort, s_valid, s_data, swap_req, rd_en, rd_kid,
    input  s_ready, load_done, swap_ack, shadow_full, rd_valid, rd_taps, active_bank
  );

  modport slave (
    input  load_start, load_kid, load_abort, s_valid, s_data, swap_req, rd_en, rd_kid,
    output s_ready, load_done, swap_ack, shadow_full, rd_valid, rd_taps, active_bank
  );

endinterface

// File: rtl/kernel_load_ctrl.sv
// Load FSM, tap counter, per-slot loaded flags and bank-swap arbitration.
//   clk, rst_n        : clock, async active-low reset
//   load_start_i/kid_i: begin loading a shadow slot; load_abort_i abandons it
//   s_valid_i/s_ready_o: tap beat handshake
//   swap_req_i        : swap request, honoured only in IDLE with every slot loaded
//   wr_en_o/kid_o/tap_o: shadow-bank write strobe and location
//   load_done_o, swap_ack_o: registered 1-cycle pulses
//   shadow_full_o, active_bank_o: status
module kernel_load_ctrl
  import npu_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int NUM_KERNELS = 4,
  localparam int KK    = kk_f(KERNEL_SIZE),
  localparam int KID_W = idx_w_f(NUM_KERNELS),
  localparam int TAP_W = idx_w_f(KK)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start_i,
  input  logic [KID_W-1:0] load_kid_i,
  input  logic             load_abort_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic             swap_req_i,
  output logic             wr_en_o,
  output logic [KID_W-1:0] wr_kid_o,
  output logic [TAP_W-1:0] wr_tap_o,
  output logic             load_done_o,
  output logic             swap_ack_o,
  output logic             shadow_full_o,
  output logic             active_bank_o
);

  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(KK - 1);

  load_state_e            state_q, state_d;
  logic [KID_W-1:0]       kid_q, kid_d;
  logic [TAP_W-1:0]       tap_q, tap_d;
  logic [NUM_KERNELS-1:0] loaded_q, loaded_d;
  logic                   active_q, active_d;
  logic                   done_q, done_d;
  logic                   ack_q, ack_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      kid_q    <= '0;
      tap_q    <= '0;
      loaded_q <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      kid_q    <= kid_d;
      tap_q    <= tap_d;
      loaded_q <= loaded_d;
      active_q <= active_d;
      done_q   <= done_d;
      ack_q    <= ack_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    kid_d    = kid_q;
    tap_d    = tap_q;
    loaded_d = loaded_q;
    active_d = active_q;
    done_d   = 1'b0;
    ack_d    = 1'b0;
    wr_en_o  = 1'b0;
    case (state_q)
      IDLE: begin
        // A load start wins over a swap so a slot being refreshed is never
        // swapped in half-written.
        if (load_start_i) begin
          state_d              = LOAD;
          kid_d                = load_kid_i;
          tap_d                = '0;
          loaded_d[load_kid_i] = 1'b0;
        end else if (swap_req_i && (&loaded_q)) begin
          active_d = ~active_q;
          loaded_d = '0;
          ack_d    = 1'b1;
        end
      end
      LOAD: begin
        // Abort takes priority over a beat offered in the same cycle.
        if (load_abort_i) begin
          state_d = IDLE;
        end else if (s_valid_i) begin
          wr_en_o = 1'b1;
          if (tap_q == LAST_TAP) begin
            state_d         = IDLE;
            loaded_d[kid_q] = 1'b1;
            done_d          = 1'b1;
          end else begin
            tap_d = tap_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_ready_o     = (state_q == LOAD);
  assign wr_kid_o      = kid_q;
  assign wr_tap_o      = tap_q;
  assign load_done_o   = done_q;
  assign swap_ack_o    = ack_q;
  assign shadow_full_o = &loaded_q;
  assign active_bank_o = active_q;

endmodule

// File: rtl/kernel_bank_buf.sv
// Double-buffered multi-kernel weight store. Host streams taps into the
// shadow bank while the MAC array reads whole kernels from the active bank;
// a handshaked swap flips the banks between layers.
//   clk   : clock, rising edge
//   rst_n : async active-low reset (weight storage is not reset)
//   bus   : kernel_bank_buf_if slave modport (load, stream, swap, read)
module kernel_bank_buf
  import npu_pkg::*;
#(
  parameter int BIT_DEPTH   = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int NUM_KERNELS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  kernel_bank_buf_if.slave  bus
);

  localparam int KK     = kk_f(KERNEL_SIZE);
  localparam int KID_W  = idx_w_f(NUM_KERNELS);
  localparam int TAP_W  = idx_w_f(KK);
  localparam int DEPTH  = 2 * NUM_KERNELS * KK;
  localparam int ADDR_W = idx_w_f(DEPTH);

  logic                    wr_en;
  logic [KID_W-1:0]        wr_kid;
  logic [TAP_W-1:0]        wr_tap;
  logic                    active_bank;
  logic                    shadow_bank;
  logic [ADDR_W-1:0]       wr_addr;
  logic [ADDR_W-1:0]       rd_base;
  logic [KK*BIT_DEPTH-1:0] rd_taps_d;
  logic [KK*BIT_DEPTH-1:0] rd_taps_q;
  logic                    rd_valid_q;
  logic [BIT_DEPTH-1:0]    mem_q [DEPTH];

  kernel_load_ctrl #(
    .KERNEL_SIZE (KERNEL_SIZE),
    .NUM_KERNELS (NUM_KERNELS)
  ) u_ctrl (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_start_i  (bus.load_start),
    .load_kid_i    (bus.load_kid),
    .load_abort_i  (bus.load_abort),
    .s_valid_i     (bus.s_valid),
    .s_ready_o     (bus.s_ready),
    .swap_req_i    (bus.swap_req),
    .wr_en_o       (wr_en),
    .wr_kid_o      (wr_kid),
    .wr_tap_o      (wr_tap),
    .load_done_o   (bus.load_done),
    .swap_ack_o    (bus.swap_ack),
    .shadow_full_o (bus.shadow_full),
    .active_bank_o (active_bank)
  );

  assign shadow_bank = ~active_bank;

  // Flat layout: bank-major, then kernel, then tap.
  always_comb begin
    wr_addr = ADDR_W'((int'(shadow_bank) * NUM_KERNELS + int'(wr_kid)) * KK + int'(wr_tap));
    rd_base = ADDR_W'((int'(active_bank) * NUM_KERNELS + int'(bus.rd_kid)) * KK);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= bus.s_data;
    end
  end

  always_comb begin
    rd_taps_d = '0;
    for (int t = 0; t < KK; t++) begin
      rd_taps_d[t*BIT_DEPTH +: BIT_DEPTH] = mem_q[rd_base + ADDR_W'(t)];
    end
  end

  // Read uses the bank index before this edge, so a read on a swap edge
  // still returns the outgoing bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_taps_q  <= '0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_taps_q <= rd_taps_d;
      end
    end
  end

  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_taps     = rd_taps_q;
  assign bus.active_bank = active_bank;

endmodule

// File: tb/tb_kernel_bank_buf.sv
module tb_kernel_bank_buf;

  localparam int BD = 8;
  localparam int KS = 3;
  localparam int NK = 4;
  localparam int KK = KS * KS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  kernel_bank_buf_if #(.BIT_DEPTH(BD), .KERNEL_SIZE(KS), .NUM_KERNELS(NK)) bus ();

  kernel_bank_buf #(.BIT_DEPTH(BD), .KERNEL_SIZE(KS), .NUM_KERNELS(NK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: two banks of kernels, per-slot loaded flags, active index.
  logic [BD-1:0] m_bank [2][NK][KK];
  bit            m_loaded [NK];
  int            m_active = 0;
  bit            m_loading = 0;
  int            m_kid = 0;
  int            m_tap = 0;
  bit            acked = 0;

  typedef struct {
    int           kind;   // 0 read data, 1 load_done, 2 swap_ack
    logic [127:0] val;
    int           due;
  } exp_t;
  exp_t q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic bad(input string msg);
    n_chk++;
    $display("FAIL %s (t=%0t)", msg, $time);
  endtask

  function automatic logic [127:0] pack_k(input int b, input int k);
    logic [127:0] v = '0;
    for (int i = 0; i < KK; i++) v[i*BD +: BD] = m_bank[b][k][i];
    return v;
  endfunction

  function automatic logic [127:0] lin(input int base);
    logic [127:0] v = '0;
    for (int i = 0; i < KK; i++) v[i*BD +: BD] = 8'(base + i);
    return v;
  endfunction

  function automatic bit all_loaded();
    bit r = 1'b1;
    for (int k = 0; k < NK; k++) r &= m_loaded[k];
    return r;
  endfunction

  // One clock: apply the rules to the current inputs, record what the DUT
  // must present after the edge, then advance.
  task automatic cycle();
    exp_t e;
    if (bus.rd_en) begin
      e.kind = 0; e.val = pack_k(m_active, int'(bus.rd_kid)); e.due = cyc + 1;
      q.push_back(e);
    end
    if (!m_loading) begin
      if (bus.load_start) begin
        m_loading = 1'b1; m_kid = int'(bus.load_kid); m_tap = 0; m_loaded[m_kid] = 1'b0;
      end else if (bus.swap_req && all_loaded()) begin
        m_active = 1 - m_active;
        for (int k = 0; k < NK; k++) m_loaded[k] = 1'b0;
        acked = 1'b1;
        e.kind = 2; e.val = 128'(m_active); e.due = cyc + 1;
        q.push_back(e);
      end
    end else if (bus.load_abort) begin
      m_loading = 1'b0;
    end else if (bus.s_valid) begin
      m_bank[1-m_active][m_kid][m_tap] = bus.s_data;
      m_tap++;
      if (m_tap == KK) begin
        m_loading = 1'b0;
        m_loaded[m_kid] = 1'b1;
        e.kind = 1; e.val = 128'(all_loaded()); e.due = cyc + 1;
        q.push_back(e);
      end
    end
    @(posedge clk); #1;
    chk("active_bank", 128'(bus.active_bank), 128'(m_active));
    chk("shadow_full", 128'(bus.shadow_full), 128'(all_loaded()));
    chk("s_ready", 128'(bus.s_ready), 128'(m_loading));
  endtask

  task automatic idle(input int n, input bit junk);
    for (int c = 0; c < n; c++) begin
      bus.s_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.s_data  = 8'($urandom);
      bus.rd_en   = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.rd_kid  = 2'($urandom_range(0, NK-1));
      cycle();
    end
    bus.s_valid = 1'b0;
    bus.rd_en   = 1'b0;
  endtask

  // base < 0 means random tap data; abort_at >= 0 aborts on that beat index.
  task automatic load_kernel(input int kid, input int base, input bit rnd,
                             input int abort_at, input bit swap_last);
    int  i = 0;
    int  guard = 0;
    bit  stop = 1'b0;
    bus.load_start = 1'b1;
    bus.load_kid   = 2'(kid);
    cycle();
    bus.load_start = 1'b0;
    while (i < KK && !stop && guard < 200) begin
      guard++;
      bus.s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.s_data  = (base < 0) ? 8'($urandom) : 8'(base + i);
      if (rnd) begin
        bus.rd_en      = 1'($urandom_range(0, 1));
        bus.rd_kid     = 2'($urandom_range(0, NK-1));
        bus.load_start = ($urandom_range(0, 5) == 0);
        bus.load_kid   = 2'($urandom_range(0, NK-1));
      end
      if (i == abort_at) begin
        bus.load_abort = 1'b1;
        bus.s_valid    = 1'b1;
        stop           = 1'b1;
      end
      if (swap_last && i == KK-1 && bus.s_valid) bus.swap_req = 1'b1;
      cycle();
      if (!stop && bus.s_valid) i++;
      bus.load_abort = 1'b0;
      bus.load_start = 1'b0;
    end
    bus.s_valid = 1'b0;
    bus.rd_en   = 1'b0;
    if (guard >= 200) bad("load_timeout");
  endtask

  task automatic do_swap(input int max, output bit got);
    acked = 1'b0;
    bus.swap_req = 1'b1;
    for (int c = 0; c < max && !acked; c++) cycle();
    bus.swap_req = 1'b0;
    got = acked;
  endtask

  task automatic read_now(input int kid);
    bus.rd_en  = 1'b1;
    bus.rd_kid = 2'(kid);
    cycle();
    bus.rd_en = 1'b0;
  endtask

  // Monitor: consume expectations whenever the DUT presents an output.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        logic         v;
        logic [127:0] a;
        int           idx;
        string        nm;
        v   = (k == 0) ? bus.rd_valid : (k == 1) ? bus.load_done : bus.swap_ack;
        a   = (k == 0) ? 128'(bus.rd_taps) : (k == 1) ? 128'(bus.shadow_full) : 128'(bus.active_bank);
        nm  = (k == 0) ? "rd_taps" : (k == 1) ? "load_done" : "swap_ack";
        idx = -1;
        for (int j = 0; j < q.size(); j++) begin
          if (idx < 0 && q[j].kind == k) idx = j;
        end
        if (v) begin
          if (idx < 0) begin
            bad({nm, " unexpected pulse"});
          end else begin
            chk(nm, a, q[idx].val);
            chk({nm, "_cycle"}, 128'(cyc), 128'(q[idx].due));
            q.delete(idx);
          end
        end
      end
      begin
        int j = 0;
        while (j < q.size()) begin
          if (q[j].due <= cyc) begin
            bad($sformatf("missing output kind %0d due cycle %0d", q[j].kind, q[j].due));
            q.delete(j);
          end else begin
            j++;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    bit got;
    bus.load_start = 1'b0; bus.load_kid = '0; bus.load_abort = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.swap_req = 1'b0;
    bus.rd_en = 1'b0; bus.rd_kid = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 128'(bus.s_ready), 0);
    chk("rst_load_done", 128'(bus.load_done), 0);
    chk("rst_swap_ack", 128'(bus.swap_ack), 0);
    chk("rst_rd_valid", 128'(bus.rd_valid), 0);
    chk("rst_rd_taps", 128'(bus.rd_taps), 0);
    chk("rst_active_bank", 128'(bus.active_bank), 0);
    chk("rst_shadow_full", 128'(bus.shadow_full), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: load all kernels, swap, read kernel 2
    for (int k = 0; k < NK; k++) load_kernel(k, 16*k + 1, 1'b0, -1, 1'b0);
    do_swap(4, got);
    chk("t1_swap_acked", 128'(got), 1);
    chk("t1_active_bank", 128'(bus.active_bank), 1);
    read_now(2);
    chk("t1_rd_k2", 128'(bus.rd_taps), lin(33));

    // 2: bursty valid, stray load_start and idle s_valid noise
    idle(6, 1'b1);
    for (int k = 0; k < 3; k++) begin
      load_kernel(k, -1, 1'b1, -1, 1'b0);
      idle(3, 1'b1);
    end

    // 3: slot 3 still empty -> swap refused, reads stay on old bank
    do_swap(5, got);
    chk("t3_no_ack", 128'(got), 0);
    read_now(1);
    chk("t3_rd_old_k1", 128'(bus.rd_taps), lin(17));
    load_kernel(3, -1, 1'b1, -1, 1'b0);
    do_swap(4, got);
    chk("t3_swap_acked", 128'(got), 1);
    for (int k = 0; k < NK; k++) read_now(k);

    // 4: abort after 5 beats, then reload the same slot
    load_kernel(1, 100, 1'b0, 5, 1'b0);
    chk("t4_abort_not_loaded", 128'(bus.shadow_full), 0);
    load_kernel(1, 200, 1'b0, -1, 1'b0);
    load_kernel(0, 40, 1'b0, -1, 1'b0);
    load_kernel(2, 120, 1'b0, -1, 1'b0);
    load_kernel(3, 70, 1'b0, -1, 1'b0);
    do_swap(4, got);
    chk("t4_swap_acked", 128'(got), 1);
    read_now(1);
    chk("t4_rd_reloaded_k1", 128'(bus.rd_taps), lin(200));

    // 5: swap_req during final beat, read on the swap edge
    for (int k = 0; k < 3; k++) load_kernel(k, -1, 1'b0, -1, 1'b0);
    acked = 1'b0;
    load_kernel(3, 60, 1'b0, -1, 1'b1);
    chk("t5_not_on_last_beat", 128'(acked), 0);
    bus.rd_en = 1'b1; bus.rd_kid = 2'd3;
    cycle();
    bus.rd_en = 1'b0; bus.swap_req = 1'b0;
    chk("t5_swap_next_cycle", 128'(acked), 1);
    chk("t5_rd_pre_swap", 128'(bus.rd_taps), lin(70));
    read_now(3);
    chk("t5_rd_post_swap", 128'(bus.rd_taps), lin(60));

    // 6: reset in the middle of a load
    bus.load_start = 1'b1; bus.load_kid = 2'd0;
    cycle();
    bus.load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.s_valid = 1'b1; bus.s_data = 8'(90 + i);
      bus.rd_en = (i == 2); bus.rd_kid = 2'd1;
      cycle();
    end
    bus.s_valid = 1'b0; bus.rd_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    m_loading = 1'b0; m_active = 0;
    for (int k = 0; k < NK; k++) m_loaded[k] = 1'b0;
    chk("t6_s_ready", 128'(bus.s_ready), 0);
    chk("t6_rd_valid", 128'(bus.rd_valid), 0);
    chk("t6_rd_taps", 128'(bus.rd_taps), 0);
    chk("t6_load_done", 128'(bus.load_done), 0);
    chk("t6_swap_ack", 128'(bus.swap_ack), 0);
    chk("t6_active_bank", 128'(bus.active_bank), 0);
    chk("t6_shadow_full", 128'(bus.shadow_full), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_shadow_full_after", 128'(bus.shadow_full), 0);

    // Random reload after reset, swap, read back every slot
    for (int k = 0; k < NK; k++) load_kernel(k, -1, 1'b1, -1, 1'b0);
    do_swap(4, got);
    chk("t6_swap_acked", 128'(got), 1);
    for (int k = 0; k < NK; k++) read_now(k);

    idle(4, 1'b0);
    chk("queue_drained", 128'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
